// File: rtl/entrada_clave_pkg.sv
// Shared constants for keypad PIN entry: key codes, PIN length
// and FSM state encoding.
package entrada_clave_pkg;

   localparam logic [3:0] TECLA_BORRAR = 4'hA;
   localparam logic [3:0] TECLA_ENTER  = 4'hB;
   localparam int         NUM_DIGITOS  = 4;

   localparam logic [1:0] INACTIVO = 2'd0;
   localparam logic [1:0] CAPTURA  = 2'd1;
   localparam logic [1:0] LLENO    = 2'd2;

   function automatic logic es_digito(input logic [3:0] c);
      return (c <= 4'd9);
   endfunction

endpackage

// File: rtl/entrada_clave_if.sv
// Keypad-side inputs and controller-side PIN outputs.
// master: keypad/controller side, slave: entrada_clave.
import entrada_clave_pkg::*;

interface entrada_clave_if;

   logic        tecla_presionada;
   logic [3:0]  tecla_codigo;
   logic        habilitado;
   logic        bloqueo;
   logic [15:0] clave_ingresada;
   logic        clave_valida;
   logic [2:0]  digitos_cnt;
   logic        error_entrada;

   modport master (
      output tecla_presionada, tecla_codigo, habilitado, bloqueo,
      input  clave_ingresada, clave_valida, digitos_cnt, error_entrada
   );

   modport slave (
      input  tecla_presionada, tecla_codigo, habilitado, bloqueo,
      output clave_ingresada, clave_valida, digitos_cnt, error_entrada
   );

endinterface

// File: rtl/entrada_clave_antirrebote.sv
// 2-FF synchronizer + debouncer on the raw key line.
// Ports: clk, reset (sync, active-low), i_tecla raw, o_evento press pulse.
module antirrebote #(
   parameter int DEBOUNCE_CICLOS = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_tecla,
   output logic o_evento
);

   localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_estable;
   logic [CW-1:0] r_cnt;
   logic          r_evento;

   assign o_evento = r_evento;

   // r_cnt counts consecutive samples disagreeing with r_estable;
   // the toggle lands on the DEBOUNCE_CICLOS-th one, so it never wraps.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_estable <= 1'b0;
         r_cnt     <= '0;
         r_evento  <= 1'b0;
      end else begin
         r_sync1  <= i_tecla;
         r_sync2  <= r_sync1;
         r_evento <= 1'b0;
         if (r_sync2 != r_estable) begin
            if (r_cnt >= CW'(DEBOUNCE_CICLOS - 1)) begin
               r_estable <= r_sync2;
               r_cnt     <= '0;
               r_evento  <= r_sync2;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/entrada_clave.sv
// Keypad PIN entry: assembles four BCD digits and strobes the PIN out.
// Ports: clk, reset (sync, active-low), bus (entrada_clave_if.slave).
import entrada_clave_pkg::*;

module entrada_clave #(
   parameter int DEBOUNCE_CICLOS = 4,
   parameter int TIMEOUT_CICLOS  = 1000
) (
   input logic           clk,
   input logic           reset,
   entrada_clave_if.slave bus
);

   localparam int IW = $clog2(TIMEOUT_CICLOS + 1);

   logic          w_evento;
   logic          w_bloq;
   logic          w_digito;
   logic          w_enter;
   logic          w_borrar;
   logic [3:0]    w_cod;

   logic [1:0]    r_estado;
   logic [15:0]   r_buf;
   logic [2:0]    r_cnt;
   logic [IW-1:0] r_idle;
   logic [15:0]   r_clave;
   logic          r_valida;
   logic          r_error;

   antirrebote #(
      .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
   ) u_antirrebote (
      .clk      (clk),
      .reset    (reset),
      .i_tecla  (bus.tecla_presionada),
      .o_evento (w_evento)
   );

   // The code is taken on the event cycle; it is stable while pressed.
   assign w_cod    = bus.tecla_codigo;
   assign w_digito = es_digito(w_cod);
   assign w_enter  = (w_cod == TECLA_ENTER);
   assign w_borrar = (w_cod == TECLA_BORRAR);
   assign w_bloq   = !bus.habilitado || bus.bloqueo;

   assign bus.clave_ingresada = r_clave;
   assign bus.clave_valida    = r_valida;
   assign bus.digitos_cnt     = r_cnt;
   assign bus.error_entrada   = r_error;

   // Priority: disable > key event > timeout.
   always_ff @(posedge clk) begin
      r_valida <= 1'b0;
      r_error  <= 1'b0;
      if (!reset) begin
         r_estado <= INACTIVO;
         r_buf    <= '0;
         r_cnt    <= '0;
         r_idle   <= '0;
         r_clave  <= '0;
      end else if (w_bloq) begin
         r_estado <= INACTIVO;
         r_buf    <= '0;
         r_cnt    <= '0;
         r_idle   <= '0;
      end else if (w_evento) begin
         r_idle <= '0;
         case (r_estado)
            INACTIVO: begin
               if (w_digito) begin
                  r_estado <= CAPTURA;
                  r_buf    <= {12'h000, w_cod};
                  r_cnt    <= 3'd1;
               end
            end
            CAPTURA: begin
               if (w_digito) begin
                  r_buf <= {r_buf[11:0], w_cod};
                  r_cnt <= r_cnt + 3'd1;
                  if (r_cnt == 3'(NUM_DIGITOS - 1))
                     r_estado <= LLENO;
               end else if (w_enter || w_borrar) begin
                  r_error  <= w_enter;
                  r_estado <= INACTIVO;
                  r_buf    <= '0;
                  r_cnt    <= '0;
               end
            end
            LLENO: begin
               if (w_enter || w_borrar) begin
                  r_valida <= w_enter;
                  if (w_enter)
                     r_clave <= r_buf;
                  r_estado <= INACTIVO;
                  r_buf    <= '0;
                  r_cnt    <= '0;
               end
            end
            default: begin
               r_estado <= INACTIVO;
               r_buf    <= '0;
               r_cnt    <= '0;
            end
         endcase
      end else if (r_estado == INACTIVO) begin
         r_idle <= '0;
      end else if (r_idle >= IW'(TIMEOUT_CICLOS - 1)) begin
         // This idle cycle is number TIMEOUT_CICLOS since the last event.
         r_error  <= 1'b1;
         r_estado <= INACTIVO;
         r_buf    <= '0;
         r_cnt    <= '0;
         r_idle   <= '0;
      end else begin
         r_idle <= r_idle + 1'b1;
      end
   end

endmodule
